// File: rtl/nios_base_timer_pkg.sv
// Register map, bit positions and FSM encoding shared by the sys_clk interval-timer host.
package nios_base_timer_pkg;

    localparam int REG_STATUS  = 0;
    localparam int REG_CONTROL = 1;
    localparam int REG_PERIODL = 2;
    localparam int REG_PERIODH = 3;

    localparam int CTRL_ITO = 0;
    localparam int STS_TO   = 0;
    localparam int STS_RUN  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_WAIT,
        ST_RD,
        ST_RDW,
        ST_CLR,
        ST_RLD,
        ST_DIS
    } state_e;

endpackage

// File: rtl/nios_base_sys_clk_timer_host.sv
// Avalon-MM master that services the sys_clk interval timer and exports a hardware timebase:
// enables the timer irq, acknowledges each timeout, and counts real and spurious services.
module nios_base_sys_clk_timer_host
    import nios_base_timer_pkg::*;
#(
    parameter int TICK_W = 32,
    parameter int MISS_W = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic              irq,
    input  logic [DATA_W-1:0] readdata,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    output logic [TICK_W-1:0] tick_count,
    output logic              tick_pulse,
    output logic [MISS_W-1:0] spurious_count,
    output logic              timer_running,
    output logic              configured
);

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic              restart_pend_q, restart_pend_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic              tick_pulse_q, tick_pulse_d;
    logic [MISS_W-1:0] spurious_count_q, spurious_count_d;
    logic              timer_running_q, timer_running_d;
    logic              configured_q, configured_d;

    // Only the TO and RUN bits of the status word carry meaning here.
    logic unused_readdata;
    assign unused_readdata = ^readdata;

    always_comb begin
        state_d          = state_q;
        // A pulse arriving during RLD re-arms the latch so that request is not dropped.
        restart_pend_d   = restart | (restart_pend_q & (state_q != ST_RLD));
        tick_count_d     = tick_count_q;
        tick_pulse_d     = 1'b0;
        spurious_count_d = spurious_count_q;
        timer_running_d  = timer_running_q;
        configured_d     = configured_q;
        address          = '0;
        chipselect       = 1'b0;
        write_n          = 1'b1;
        writedata        = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_CFG;
            end
            ST_CFG: begin
                chipselect          = 1'b1;
                write_n             = 1'b0;
                address             = ADDR_W'(REG_CONTROL);
                writedata[CTRL_ITO] = 1'b1;
                configured_d        = 1'b1;
                state_d             = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable)             state_d = ST_DIS;
                else if (irq)            state_d = ST_RD;
                else if (restart_pend_q) state_d = ST_RLD;
            end
            ST_RD: begin
                chipselect = 1'b1;
                address    = ADDR_W'(REG_STATUS);
                state_d    = ST_RDW;
            end
            ST_RDW: begin
                if (readdata[STS_TO]) begin
                    tick_count_d = tick_count_q + 1'b1;
                    tick_pulse_d = 1'b1;
                end else begin
                    spurious_count_d = sat_inc(spurious_count_q);
                end
                timer_running_d = readdata[STS_RUN];
                state_d         = ST_CLR;
            end
            ST_CLR: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_W'(REG_STATUS);
                state_d    = ST_WAIT;
            end
            ST_RLD: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_W'(REG_PERIODL);
                state_d    = ST_WAIT;
            end
            ST_DIS: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = ADDR_W'(REG_CONTROL);
                configured_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            restart_pend_q   <= 1'b0;
            tick_count_q     <= '0;
            tick_pulse_q     <= 1'b0;
            spurious_count_q <= '0;
            timer_running_q  <= 1'b0;
            configured_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            restart_pend_q   <= restart_pend_d;
            tick_count_q     <= tick_count_d;
            tick_pulse_q     <= tick_pulse_d;
            spurious_count_q <= spurious_count_d;
            timer_running_q  <= timer_running_d;
            configured_q     <= configured_d;
        end
    end

    assign tick_count     = tick_count_q;
    assign tick_pulse     = tick_pulse_q;
    assign spurious_count = spurious_count_q;
    assign timer_running  = timer_running_q;
    assign configured     = configured_q;

endmodule

// File: tb/tb_nios_base_sys_clk_timer_host.sv
// Directed bench for the timer host against a small behavioural model of the timer s1 slave.
// Counters are built narrow (TICK_W=8, MISS_W=4) so wrap and saturation are reachable quickly.
module tb_nios_base_sys_clk_timer_host;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic        irq;
    logic [15:0] readdata;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [7:0]  tick_count;
    logic        tick_pulse;
    logic [3:0]  spurious_count;
    logic        timer_running;
    logic        configured;

    int n_checks = 0;
    int n_errors = 0;

    nios_base_sys_clk_timer_host #(
        .TICK_W(8), .MISS_W(4), .ADDR_W(3), .DATA_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart), .irq(irq),
        .readdata(readdata), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .tick_count(tick_count), .tick_pulse(tick_pulse),
        .spurious_count(spurious_count), .timer_running(timer_running), .configured(configured)
    );

    always #5 clk = ~clk;

    // Timer slave model: countdown, TO/RUN status, ITO control, registered readdata.
    logic        ito, to_bit, run_bit, force_sts, irq_force;
    logic [15:0] force_val;
    int          cnt;
    int          period = 20;

    assign irq = (to_bit & ito) | irq_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ito      <= 1'b0;
            to_bit   <= 1'b0;
            readdata <= 16'h0;
            cnt      <= 0;
        end else begin
            if (run_bit) begin
                if (cnt == 0) begin
                    cnt    <= period;
                    to_bit <= 1'b1;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: to_bit <= 1'b0;
                    3'd1: ito    <= writedata[0];
                    3'd2: cnt    <= period;
                    default: ;
                endcase
            end
            if (chipselect && write_n && address == 3'd0)
                readdata <= force_sts ? force_val : {14'h0, run_bit, to_bit};
        end
    end

    int pulse_cnt = 0;
    int rld_cnt   = 0;
    always @(negedge clk) begin
        if (tick_pulse) pulse_cnt <= pulse_cnt + 1;
        if (chipselect && !write_n && address == 3'd2) rld_cnt <= rld_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bus(input logic [2:0] a, input logic wr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (chipselect && (write_n == !wr) && address == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic forced_service(input logic [15:0] sts, output bit ok);
        bit ok_rd, ok_clr;
        force_sts = 1'b1;
        force_val = sts;
        irq_force = 1'b1;
        wait_bus(3'd0, 1'b0, 6, ok_rd);
        irq_force = 1'b0;
        wait_bus(3'd0, 1'b1, 6, ok_clr);
        ok = ok_rd & ok_clr;
    endtask

    initial begin
        bit ok;
        int lat, p0, r0;
        reset_n = 1'b0; enable = 1'b0; restart = 1'b0;
        run_bit = 1'b0; force_sts = 1'b0; irq_force = 1'b0; force_val = 16'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_cs", chipselect, 0);
        check_eq("rst_wr_n", write_n, 1);
        check_eq("rst_addr", address, 0);
        check_eq("rst_wdata", writedata, 0);
        check_eq("rst_outs", {tick_count, tick_pulse, spurious_count, timer_running, configured}, 0);
        reset_n = 1'b1;

        // Enable: CFG write on the next cycle, then bus idle with configured set
        enable = 1'b1;
        @(negedge clk);
        check_eq("cfg_bus", {chipselect, write_n, address}, {1'b1, 1'b0, 3'd1});
        check_eq("cfg_wdata", writedata, 16'h0001);
        @(negedge clk);
        check_eq("cfg_done", {configured, chipselect}, 2'b10);

        // Three real timeouts from the running timer model
        p0 = pulse_cnt;
        run_bit = 1'b1;
        for (int t = 0; t < 3; t++) begin
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (irq) begin ok = 1'b1; break; end
            end
            check_eq("irq_seen", ok, 1);
            lat = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                lat++;
                if (tick_pulse) break;
            end
            check_eq("tick_latency", lat, 3);
        end
        run_bit = 1'b0;
        @(negedge clk);
        check_eq("tick_count_3", tick_count, 3);
        check_eq("pulses_3", pulse_cnt - p0, 3);
        check_eq("running_3", timer_running, 1);

        // Spurious irq with status RUN only
        forced_service(16'h0002, ok);
        check_eq("spur_clr_issued", ok, 1);
        check_eq("spur_count", spurious_count, 1);
        check_eq("spur_tick_hold", {tick_count, tick_pulse}, {8'd3, 1'b0});
        check_eq("spur_running", timer_running, 1);

        // Two back-to-back restart cycles collapse into one reload
        r0 = rld_cnt;
        @(negedge clk); restart = 1'b1;
        @(negedge clk);
        @(negedge clk); restart = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("restart_once", rld_cnt - r0, 1);
        check_eq("restart_idle", chipselect, 0);

        // restart and irq together: service first, reload after
        r0 = rld_cnt;
        force_sts = 1'b1; force_val = 16'h0003;
        restart = 1'b1; irq_force = 1'b1;
        wait_bus(3'd0, 1'b0, 3, ok);
        check_eq("both_rd_first", ok, 1);
        restart = 1'b0; irq_force = 1'b0;
        wait_bus(3'd0, 1'b1, 3, ok);
        check_eq("both_clr", ok, 1);
        check_eq("both_tick", {tick_count, tick_pulse}, {8'd4, 1'b1});
        wait_bus(3'd2, 1'b1, 4, ok);
        check_eq("both_rld_after", ok, 1);
        repeat (4) @(negedge clk);
        check_eq("both_rld_once", rld_cnt - r0, 1);

        // enable drops during RDW: CLR completes, then DIS
        force_val = 16'h0001; irq_force = 1'b1;
        wait_bus(3'd0, 1'b0, 4, ok);
        irq_force = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        wait_bus(3'd0, 1'b1, 2, ok);
        check_eq("dis_clr_first", ok, 1);
        wait_bus(3'd1, 1'b1, 3, ok);
        check_eq("dis_write", ok, 1);
        check_eq("dis_wdata", writedata, 16'h0000);
        @(negedge clk);
        check_eq("dis_done", {configured, chipselect}, 2'b00);
        check_eq("dis_tick", tick_count, 5);

        // Re-enable, then saturate the spurious counter (16 more -> 15)
        enable = 1'b1;
        wait_bus(3'd1, 1'b1, 3, ok);
        check_eq("reen_cfg", {ok, writedata}, {1'b1, 16'h0001});
        for (int i = 0; i < 16; i++) begin
            forced_service(16'h0000, ok);
            check_eq("sat_service", ok, 1);
        end
        check_eq("spur_saturated", spurious_count, 15);
        check_eq("sat_tick_hold", tick_count, 5);

        // Wrap tick_count 0xFF -> 0 with the pulse still asserted
        for (int i = 0; i < 250; i++) begin
            forced_service(16'h0001, ok);
            check_eq("wrap_service", ok, 1);
        end
        @(negedge clk);
        check_eq("tick_max", tick_count, 8'hFF);
        forced_service(16'h0001, ok);
        check_eq("wrap_clr", ok, 1);
        check_eq("wrap_tick", {tick_count, tick_pulse}, {8'h00, 1'b1});

        // Async reset in mid-transaction
        force_val = 16'h0001; irq_force = 1'b1;
        wait_bus(3'd0, 1'b0, 4, ok);
        irq_force = 1'b0;
        check_eq("arst_rd", ok, 1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("arst_bus", {chipselect, write_n, address, writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        check_eq("arst_outs", {tick_count, tick_pulse, spurious_count, timer_running, configured}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
